// File: rtl/scan_risk_engine.sv
// Sequential scanning-risk calculator: sweeps nine price scenarios over eight
// positions and reports the worst portfolio loss, floored at 0 and saturated to 16 bits.
module scan_risk_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] price_scan_range,
    output logic [2:0]  pos_idx,
    input  logic [15:0] pos_data,
    output logic [15:0] scanning_risk,
    output logic [3:0]  worst_scenario,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_ACCUM,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic signed [35:0] MAX_INIT  = {1'b1, 35'd0};
    localparam logic [3:0]         LAST_SCEN = 4'd8;

    state_t state_q, state_d;

    logic [15:0]        range_q;
    logic [3:0]         scen_q;
    logic [2:0]         idx_q;
    logic signed [18:0] move_q;
    logic signed [35:0] acc_q;
    logic signed [35:0] max_q;
    logic [3:0]         arg_q;

    // Q8 scenario fractions: 0, +-1/3, +-2/3, +-1, +-1.05 (extreme move).
    function automatic logic signed [9:0] scen_frac(input logic [3:0] s);
        case (s)
            4'd1:    scen_frac =  10'sd85;
            4'd2:    scen_frac = -10'sd85;
            4'd3:    scen_frac =  10'sd171;
            4'd4:    scen_frac = -10'sd171;
            4'd5:    scen_frac =  10'sd256;
            4'd6:    scen_frac = -10'sd256;
            4'd7:    scen_frac =  10'sd269;
            4'd8:    scen_frac = -10'sd269;
            default: scen_frac =  10'sd0;
        endcase
    endfunction

    function automatic logic [15:0] saturate(input logic signed [35:0] v);
        if (v <= 36'sd0)
            saturate = 16'd0;
        else if (v > 36'sd65535)
            saturate = 16'hFFFF;
        else
            saturate = v[15:0];
    endfunction

    // Widths are chosen so the full-scale corner (R=0xFFFF, extreme scenario,
    // |pos|=0x8000) never wraps in the product, the loss or the sum.
    logic signed [26:0] range_ext;
    logic signed [26:0] frac_ext;
    logic signed [26:0] move_prod;
    logic signed [35:0] pos_ext;
    logic signed [35:0] move_ext;
    logic signed [35:0] loss;

    assign range_ext = 27'({1'b0, range_q});
    assign frac_ext  = 27'(scen_frac(scen_q));
    assign move_prod = range_ext * frac_ext;
    assign pos_ext   = 36'($signed(pos_data));
    assign move_ext  = 36'(move_q);
    assign loss      = -(pos_ext * move_ext);

    logic               take_new;
    logic signed [35:0] best_val;
    logic [3:0]         best_idx;

    // Strict compare keeps the lowest scenario index on ties.
    assign take_new = (acc_q > max_q);
    assign best_val = take_new ? acc_q  : max_q;
    assign best_idx = take_new ? scen_q : arg_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        pos_idx = 3'd0;
        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_MOVE;
            end
            S_MOVE: begin
                busy    = 1'b1;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                busy    = 1'b1;
                pos_idx = idx_q;
                if (idx_q == 3'd7)
                    state_d = S_COMPARE;
            end
            S_COMPARE: begin
                busy    = 1'b1;
                state_d = (scen_q == LAST_SCEN) ? S_DONE : S_MOVE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            range_q        <= 16'd0;
            scen_q         <= 4'd0;
            idx_q          <= 3'd0;
            move_q         <= 19'sd0;
            acc_q          <= 36'sd0;
            max_q          <= MAX_INIT;
            arg_q          <= 4'd0;
            scanning_risk  <= 16'd0;
            worst_scenario <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        range_q <= price_scan_range;
                        scen_q  <= 4'd0;
                        max_q   <= MAX_INIT;
                        arg_q   <= 4'd0;
                    end
                end
                S_MOVE: begin
                    // Dropping the low 8 bits of a signed product is an
                    // arithmetic shift, so the move floors toward -inf.
                    move_q <= move_prod[26:8];
                    acc_q  <= 36'sd0;
                    idx_q  <= 3'd0;
                end
                S_ACCUM: begin
                    acc_q <= acc_q + loss;
                    idx_q <= idx_q + 3'd1;
                end
                S_COMPARE: begin
                    max_q <= best_val;
                    arg_q <= best_idx;
                    if (scen_q == LAST_SCEN) begin
                        scanning_risk  <= saturate(best_val);
                        worst_scenario <= best_idx;
                    end else begin
                        scen_q <= scen_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_risk_engine.sv
// Directed bench for scan_risk_engine: hand-computed scenario results, fixed
// 90-cycle latency, ignored restart, and mid-calculation reset.
module tb_scan_risk_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] price_scan_range;
    logic [2:0]  pos_idx;
    logic [15:0] pos_data;
    logic [15:0] scanning_risk;
    logic [3:0]  worst_scenario;
    logic        busy;
    logic        done;

    logic [15:0] pos_mem [8];
    int total;
    int bad;

    assign pos_data = pos_mem[pos_idx];

    scan_risk_engine dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .price_scan_range (price_scan_range),
        .pos_idx          (pos_idx),
        .pos_data         (pos_data),
        .scanning_risk    (scanning_risk),
        .worst_scenario   (worst_scenario),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic set_positions(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] rest);
        pos_mem[0] = p0;
        pos_mem[1] = p1;
        for (int i = 2; i < 8; i++) pos_mem[i] = rest;
    endtask

    // Runs one calculation; inject_k > 0 pulses a second start (with another R)
    // at that many cycles after the accepting edge.
    task automatic run_calc(input string tag, input logic [15:0] r,
                            input logic [15:0] exp_risk, input logic [3:0] exp_worst,
                            input int inject_k);
        int         lat;
        int         busy_cnt;
        int         idx_err;
        logic [2:0] exp_idx;
        lat      = 0;
        busy_cnt = 0;
        idx_err  = 0;
        @(negedge clk);
        start            = 1'b1;
        price_scan_range = r;
        @(posedge clk);
        #1;
        start            = 1'b0;
        price_scan_range = 16'h1234;
        if (busy) busy_cnt++;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            start = (k == inject_k);
            if (k == inject_k) price_scan_range = 16'd1000;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
            exp_idx = ((k % 10) >= 1 && (k % 10) <= 8) ? 3'((k % 10) - 1) : 3'd0;
            if (pos_idx !== exp_idx) idx_err++;
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, 90);
        check({tag, "_busy_cycles"}, busy_cnt, 90);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_pos_idx_seq_errs"}, idx_err, 0);
        check({tag, "_risk"}, scanning_risk, exp_risk);
        check({tag, "_worst"}, worst_scenario, exp_worst);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        int done_seen;
        total            = 0;
        bad              = 0;
        reset            = 1'b0;
        start            = 1'b0;
        price_scan_range = 16'd0;
        set_positions(16'd0, 16'd0, 16'd0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_risk", scanning_risk, 0);
        check("rst_worst", worst_scenario, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pos_idx", pos_idx, 0);
        reset = 1'b1;

        set_positions(16'd0, 16'd0, 16'd0);
        run_calc("zero_pos", 16'd300, 16'd0, 4'd0, 0);

        set_positions(16'd10, 16'd0, 16'd0);
        run_calc("long10", 16'd300, 16'd3160, 4'd8, 0);

        set_positions(-16'sd10, 16'd0, 16'd0);
        run_calc("short10", 16'd300, 16'd3150, 4'd7, 0);

        set_positions(16'd5, -16'sd5, 16'd0);
        run_calc("hedged", 16'd300, 16'd0, 4'd0, 0);

        set_positions(16'h7FFF, 16'h7FFF, 16'h7FFF);
        run_calc("saturate", 16'hFFFF, 16'hFFFF, 4'd8, 0);

        set_positions(16'd10, 16'd0, 16'd0);
        run_calc("restart_ignored", 16'd300, 16'd3160, 4'd8, 20);

        // Abort mid-calculation; outputs currently hold a nonzero result.
        @(negedge clk);
        start            = 1'b1;
        price_scan_range = 16'd300;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_risk", scanning_risk, 0);
        check("abort_worst", worst_scenario, 0);
        check("abort_pos_idx", pos_idx, 0);
        reset     = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 120; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("abort_no_activity", done_seen, 0);

        set_positions(-16'sd10, 16'd0, 16'd0);
        run_calc("after_abort", 16'd300, 16'd3150, 4'd7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
